// File: rtl/and4_out_qualifier.sv
// -----------------------------------------------------------------------------
// and4_out_qualifier
//
// Cleans up the output of a 4-input AND cell before the rest of the clock
// domain uses it. The raw AND output is asynchronous, so it first passes
// through a reset-clearable synchronizer. A four-state persistence FSM then
// applies hysteresis:
//   - Q rises only after ON_CYCLES consecutive high samples.
//   - Q falls only after OFF_CYCLES consecutive low samples.
// Short glitches on the AND output therefore never reach Q.
//
// Parameters
//   SYNC_STAGES : synchronizer depth, >= 2
//   ON_CYCLES   : consecutive high samples needed to assert Q, 1..2**CNT_W-1
//   OFF_CYCLES  : consecutive low samples needed to drop Q, 1..2**CNT_W-1
//   CNT_W       : persistence counter width
//
// Ports
//   CLK  : clock, rising edge
//   RN   : asynchronous active-low reset
//   I    : AND4 output Z, asynchronous to CLK
//   EN   : synchronous enable; low forces IDLE on the next edge
//   Q    : qualified level, registered (high in ON and REL)
//   QP   : one-cycle pulse on entry to ON from IDLE or QUAL, registered
//   BUSY : high while counting (QUAL or REL), registered
// -----------------------------------------------------------------------------
module and4_out_qualifier #(
  parameter int SYNC_STAGES = 2,
  parameter int ON_CYCLES   = 4,
  parameter int OFF_CYCLES  = 2,
  parameter int CNT_W       = 4
) (
  input  logic CLK,
  input  logic RN,
  input  logic I,
  input  logic EN,
  output logic Q,
  output logic QP,
  output logic BUSY
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Reject parameter sets the counter cannot represent or that break the
  // synchronizer, before any hardware is built from them.
  generate
    if (SYNC_STAGES < 2 || CNT_W < 1 || CNT_W > 30 ||
        ON_CYCLES < 1 || ON_CYCLES > CNT_MAX ||
        OFF_CYCLES < 1 || OFF_CYCLES > CNT_MAX) begin : g_bad_params
      $error("and4_out_qualifier: illegal SYNC_STAGES/ON_CYCLES/OFF_CYCLES/CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_QUAL = 2'd1,
    ST_ON   = 2'd2,
    ST_REL  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronizer. It runs regardless of EN, so a level that is already high
  // when EN returns is seen without the synchronizer latency.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  // NOTE: the chain is reset even though it is only a delay line; otherwise a
  // stale high left from before reset could qualify without a real input.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its
      // predecessor's old value, which is what makes this a shift register.
      sync_q <= {sync_q[SYNC_STAGES-2:0], I};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Persistence FSM: state register, next-state logic, output decode.
  // ---------------------------------------------------------------------------
  state_t           state_q, state_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic             q_nx, qp_nx, busy_nx;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      Q       <= 1'b0;
      QP      <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      Q       <= q_nx;
      QP      <= qp_nx;
      BUSY    <= busy_nx;
    end
  end

  always_comb begin
    // NOTE: defaults first so that every path assigns both signals and no
    // latch is inferred.
    state_nx = state_q;
    cnt_nx   = CNT_ZERO;

    if (!EN) begin
      // EN dominates the sampled input in every state.
      state_nx = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (s) begin
            if (ON_CYCLES == 1) begin
              state_nx = ST_ON;
            end else begin
              state_nx = ST_QUAL;
              cnt_nx   = CNT_ONE;
            end
          end
        end

        ST_QUAL: begin
          if (!s) begin
            state_nx = ST_IDLE;            // any low sample restarts from zero
          end else if (cnt_q == ON_LAST) begin
            state_nx = ST_ON;
          end else begin
            cnt_nx = cnt_q + CNT_ONE;
          end
        end

        ST_ON: begin
          if (!s) begin
            if (OFF_CYCLES == 1) begin
              state_nx = ST_IDLE;
            end else begin
              state_nx = ST_REL;
              cnt_nx   = CNT_ONE;
            end
          end
        end

        ST_REL: begin
          if (s) begin
            state_nx = ST_ON;              // any high sample cancels release
          end else if (cnt_q == OFF_LAST) begin
            state_nx = ST_IDLE;
          end else begin
            cnt_nx = cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs come from the next state so that the registered copies line up
  // with the state they describe. QP is suppressed on REL->ON, which is a
  // cancelled release rather than a new assertion.
  always_comb begin
    q_nx    = (state_nx == ST_ON)   || (state_nx == ST_REL);
    busy_nx = (state_nx == ST_QUAL) || (state_nx == ST_REL);
    qp_nx   = (state_nx == ST_ON) &&
              ((state_q == ST_IDLE) || (state_q == ST_QUAL));
  end

endmodule
